// File: rtl/cpu_pkg.sv
// Shared mini-SRC control definitions: opcodes, sequencer states, instruction
// classes and the control-word layout produced by the control unit.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        RESET, T0, T1, T2, T3, T4, T5, T6, T7, T8, T9, HALT
    } state_t;

    typedef enum logic [3:0] {
        CL_ALU, CL_IMM, CL_UNARY, CL_MULDIV, CL_LOAD, CL_STORE,
        CL_BRANCH, CL_JUMP, CL_IO, CL_MOVE, CL_NOP, CL_HALT
    } iclass_t;

    typedef struct packed {
        logic HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
        logic HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout;
        logic Gra, Grb, Grc, Rin, Rout, BAout;
        logic Read, IncPC, write;
        logic link;
    } ctrl_t;

    function automatic iclass_t op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
            OP_SHL, OP_ROR, OP_ROL:          op_class = CL_ALU;
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: op_class = CL_IMM;
            OP_NEG, OP_NOT:                  op_class = CL_UNARY;
            OP_MUL, OP_DIV:                  op_class = CL_MULDIV;
            OP_LD:                           op_class = CL_LOAD;
            OP_ST:                           op_class = CL_STORE;
            OP_BR:                           op_class = CL_BRANCH;
            OP_JR, OP_JAL:                   op_class = CL_JUMP;
            OP_IN, OP_OUT:                   op_class = CL_IO;
            OP_MFHI, OP_MFLO:                op_class = CL_MOVE;
            OP_HALT:                         op_class = CL_HALT;
            default:                         op_class = CL_NOP;
        endcase
    endfunction

    // Final execute step of each instruction; the step after it is T0.
    function automatic state_t last_step(input logic [4:0] op);
        case (op_class(op))
            CL_ALU, CL_IMM:          last_step = T6;
            CL_UNARY:                last_step = T5;
            CL_MULDIV, CL_BRANCH:    last_step = T7;
            CL_LOAD:                 last_step = T9;
            CL_STORE:                last_step = T8;
            CL_JUMP:                 last_step = (op == OP_JAL) ? T5 : T4;
            default:                 last_step = T4;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between the control unit and the mini-SRC datapath.
interface control_unit_if;
    logic        Stop;
    logic [31:0] IR;
    logic        CON;
    logic        Run;
    logic        HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
    logic        HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        Read, IncPC, write;
    logic [15:0] regIn;

    modport master (
        input  Stop, IR, CON,
        output Run,
        output HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
        output HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output Read, IncPC, write, regIn
    );

    modport slave (
        output Stop, IR, CON,
        input  Run,
        input  HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
        input  HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  Read, IncPC, write, regIn
    );
endinterface

// File: rtl/control_unit.sv
// Hardwired mini-SRC sequencer: fetch in T0-T3, opcode-specific execute from
// T4, one control step per clock; controls are a Moore decode of state and IR.
module control_unit
    import cpu_pkg::*;
(
    input  logic           Clock,
    input  logic           clr,
    control_unit_if.master bus
);

    state_t     state_q, state_d;
    ctrl_t      ctrl;
    logic [4:0] op;
    iclass_t    cls;
    logic       unused_ir;

    assign op        = bus.IR[31:27];
    assign cls       = op_class(op);
    assign unused_ir = ^bus.IR[26:0];

    always_ff @(posedge Clock) begin
        if (clr) state_q <= RESET;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET:   state_d = T0;
            T0:      state_d = bus.Stop ? T0 : T1;
            T1:      state_d = T2;
            T2:      state_d = T3;
            T3:      state_d = T4;
            HALT:    state_d = HALT;
            default: begin
                if (state_q == T4 && cls == CL_HALT)
                    state_d = HALT;
                else if (state_q == last_step(op))
                    state_d = T0;
                else
                    state_d = state_t'(state_q + 4'd1);
            end
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            RESET, HALT: ;
            // A paused T0 must not advance the PC, so its controls are gated by Stop.
            T0: if (!bus.Stop) begin
                ctrl.PCout = 1'b1; ctrl.MARin = 1'b1; ctrl.IncPC = 1'b1; ctrl.Zin = 1'b1;
            end
            T1: begin ctrl.ZLOout = 1'b1; ctrl.PCin  = 1'b1; end
            T2: begin ctrl.Read   = 1'b1; ctrl.MDRin = 1'b1; end
            T3: begin ctrl.MDRout = 1'b1; ctrl.IRin  = 1'b1; end
            default: begin
                case (cls)
                    CL_ALU: case (state_q)
                        T4: begin ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Yin = 1'b1; end
                        T5: begin ctrl.Grc = 1'b1; ctrl.Rout = 1'b1; ctrl.Zin = 1'b1; end
                        T6: begin ctrl.ZLOout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
                        default: ;
                    endcase
                    CL_IMM: case (state_q)
                        T4: begin
                            ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Yin = 1'b1;
                            ctrl.BAout = (op == OP_LDI);
                        end
                        T5: begin ctrl.Cout = 1'b1; ctrl.Zin = 1'b1; end
                        T6: begin ctrl.ZLOout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
                        default: ;
                    endcase
                    CL_UNARY: case (state_q)
                        T4: begin ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Zin = 1'b1; end
                        T5: begin ctrl.ZLOout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
                        default: ;
                    endcase
                    CL_MULDIV: case (state_q)
                        T4: begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.Yin = 1'b1; end
                        T5: begin ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Zin = 1'b1; end
                        T6: begin ctrl.ZLOout = 1'b1; ctrl.LOin = 1'b1; end
                        T7: begin ctrl.ZHIout = 1'b1; ctrl.HIin = 1'b1; end
                        default: ;
                    endcase
                    CL_LOAD, CL_STORE: case (state_q)
                        T4: begin
                            ctrl.Grb = 1'b1; ctrl.BAout = 1'b1; ctrl.Rout = 1'b1; ctrl.Yin = 1'b1;
                        end
                        T5: begin ctrl.Cout = 1'b1; ctrl.Zin = 1'b1; end
                        T6: begin ctrl.ZLOout = 1'b1; ctrl.MARin = 1'b1; end
                        // Loads spend T7 waiting on memory; stores drive the data register.
                        T7: if (cls == CL_STORE) begin
                            ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.MDRin = 1'b1;
                        end
                        T8: if (cls == CL_STORE) ctrl.write = 1'b1;
                            else begin ctrl.Read = 1'b1; ctrl.MDRin = 1'b1; end
                        T9: if (cls == CL_LOAD) begin
                            ctrl.MDRout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1;
                        end
                        default: ;
                    endcase
                    CL_BRANCH: case (state_q)
                        T4: begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.CONin = 1'b1; end
                        T5: begin ctrl.PCout = 1'b1; ctrl.Yin = 1'b1; end
                        T6: begin ctrl.Cout = 1'b1; ctrl.Zin = 1'b1; end
                        T7: if (bus.CON) begin ctrl.ZLOout = 1'b1; ctrl.PCin = 1'b1; end
                        default: ;
                    endcase
                    CL_JUMP: begin
                        if (op == OP_JR) begin
                            if (state_q == T4) begin
                                ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.PCin = 1'b1;
                            end
                        end else begin
                            if (state_q == T4) begin ctrl.PCout = 1'b1; ctrl.link = 1'b1; end
                            if (state_q == T5) begin
                                ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.PCin = 1'b1;
                            end
                        end
                    end
                    CL_IO: if (state_q == T4) begin
                        ctrl.Gra = 1'b1;
                        if (op == OP_IN) begin ctrl.INPORTout = 1'b1; ctrl.Rin = 1'b1; end
                        else begin ctrl.Rout = 1'b1; ctrl.OUTPORTin = 1'b1; end
                    end
                    CL_MOVE: if (state_q == T4) begin
                        ctrl.Gra = 1'b1; ctrl.Rin = 1'b1;
                        if (op == OP_MFHI) ctrl.HIout = 1'b1;
                        else               ctrl.LOout = 1'b1;
                    end
                    default: ;
                endcase
            end
        endcase
    end

    assign bus.Run       = (state_q != RESET) && (state_q != HALT);
    assign bus.HIin      = ctrl.HIin;
    assign bus.LOin      = ctrl.LOin;
    assign bus.PCin      = ctrl.PCin;
    assign bus.MDRin     = ctrl.MDRin;
    assign bus.Zin       = ctrl.Zin;
    assign bus.Yin       = ctrl.Yin;
    assign bus.MARin     = ctrl.MARin;
    assign bus.IRin      = ctrl.IRin;
    assign bus.CONin     = ctrl.CONin;
    assign bus.OUTPORTin = ctrl.OUTPORTin;
    assign bus.HIout     = ctrl.HIout;
    assign bus.LOout     = ctrl.LOout;
    assign bus.ZHIout    = ctrl.ZHIout;
    assign bus.ZLOout    = ctrl.ZLOout;
    assign bus.PCout     = ctrl.PCout;
    assign bus.MDRout    = ctrl.MDRout;
    assign bus.INPORTout = ctrl.INPORTout;
    assign bus.Cout      = ctrl.Cout;
    assign bus.Gra       = ctrl.Gra;
    assign bus.Grb       = ctrl.Grb;
    assign bus.Grc       = ctrl.Grc;
    assign bus.Rin       = ctrl.Rin;
    assign bus.Rout      = ctrl.Rout;
    assign bus.BAout     = ctrl.BAout;
    assign bus.Read      = ctrl.Read;
    assign bus.IncPC     = ctrl.IncPC;
    assign bus.write     = ctrl.write;
    assign bus.regIn     = {ctrl.link, 15'b0};

endmodule

// File: tb/tb_control_unit.sv
// Randomized scoreboard bench for control_unit: a per-instruction step-list
// model predicts every cycle's control word; a monitor compares at negedge.
module tb_control_unit;

    logic Clock = 1'b0;
    logic clr;

    control_unit_if cif();
    control_unit dut (.Clock(Clock), .clr(clr), .bus(cif.master));

    always #5 Clock = ~Clock;

    localparam logic [43:0] C_RUN    = 44'h1 << 43;
    localparam logic [43:0] C_HIIN   = 44'h1 << 42;
    localparam logic [43:0] C_LOIN   = 44'h1 << 41;
    localparam logic [43:0] C_PCIN   = 44'h1 << 40;
    localparam logic [43:0] C_MDRIN  = 44'h1 << 39;
    localparam logic [43:0] C_ZIN    = 44'h1 << 38;
    localparam logic [43:0] C_YIN    = 44'h1 << 37;
    localparam logic [43:0] C_MARIN  = 44'h1 << 36;
    localparam logic [43:0] C_IRIN   = 44'h1 << 35;
    localparam logic [43:0] C_CONIN  = 44'h1 << 34;
    localparam logic [43:0] C_OUTIN  = 44'h1 << 33;
    localparam logic [43:0] C_HIOUT  = 44'h1 << 32;
    localparam logic [43:0] C_LOOUT  = 44'h1 << 31;
    localparam logic [43:0] C_ZHIOUT = 44'h1 << 30;
    localparam logic [43:0] C_ZLOOUT = 44'h1 << 29;
    localparam logic [43:0] C_PCOUT  = 44'h1 << 28;
    localparam logic [43:0] C_MDROUT = 44'h1 << 27;
    localparam logic [43:0] C_INOUT  = 44'h1 << 26;
    localparam logic [43:0] C_COUT   = 44'h1 << 25;
    localparam logic [43:0] C_GRA    = 44'h1 << 24;
    localparam logic [43:0] C_GRB    = 44'h1 << 23;
    localparam logic [43:0] C_GRC    = 44'h1 << 22;
    localparam logic [43:0] C_RIN    = 44'h1 << 21;
    localparam logic [43:0] C_ROUT   = 44'h1 << 20;
    localparam logic [43:0] C_BAOUT  = 44'h1 << 19;
    localparam logic [43:0] C_READ   = 44'h1 << 18;
    localparam logic [43:0] C_INCPC  = 44'h1 << 17;
    localparam logic [43:0] C_WRITE  = 44'h1 << 16;
    localparam logic [43:0] C_LINK   = 44'h1 << 15;
    localparam int          N_TOTAL  = 320;

    typedef struct {
        logic [31:0] ir;
        bit          con;
        int          stop_n;
        int          clr_step;
    } instr_t;

    typedef enum {M_RESET, M_RUN, M_HALT} mode_t;

    instr_t       prog[$];
    logic [43:0]  steps[$];
    logic [43:0]  exp_q[$];
    bit           cur_halt;
    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;

    function automatic logic [43:0] sample();
        return {cif.Run, cif.HIin, cif.LOin, cif.PCin, cif.MDRin, cif.Zin, cif.Yin,
                cif.MARin, cif.IRin, cif.CONin, cif.OUTPORTin, cif.HIout, cif.LOout,
                cif.ZHIout, cif.ZLOout, cif.PCout, cif.MDRout, cif.INPORTout, cif.Cout,
                cif.Gra, cif.Grb, cif.Grc, cif.Rin, cif.Rout, cif.BAout, cif.Read,
                cif.IncPC, cif.write, cif.regIn};
    endfunction

    // Full list of per-cycle control words for one instruction, fetch included.
    function automatic void load_seq(input logic [4:0] op, input bit con);
        logic [43:0] ba;
        steps.delete();
        cur_halt = 1'b0;
        steps.push_back(C_RUN | C_PCOUT | C_MARIN | C_INCPC | C_ZIN);
        steps.push_back(C_RUN | C_ZLOOUT | C_PCIN);
        steps.push_back(C_RUN | C_READ | C_MDRIN);
        steps.push_back(C_RUN | C_MDROUT | C_IRIN);
        if (op >= 5'd3 && op <= 5'd11) begin
            steps.push_back(C_RUN | C_GRB | C_ROUT | C_YIN);
            steps.push_back(C_RUN | C_GRC | C_ROUT | C_ZIN);
            steps.push_back(C_RUN | C_ZLOOUT | C_GRA | C_RIN);
        end else if (op == 5'd1 || op == 5'd12 || op == 5'd13 || op == 5'd14) begin
            ba = (op == 5'd1) ? C_BAOUT : 44'h0;
            steps.push_back(C_RUN | C_GRB | C_ROUT | C_YIN | ba);
            steps.push_back(C_RUN | C_COUT | C_ZIN);
            steps.push_back(C_RUN | C_ZLOOUT | C_GRA | C_RIN);
        end else if (op == 5'd17 || op == 5'd18) begin
            steps.push_back(C_RUN | C_GRB | C_ROUT | C_ZIN);
            steps.push_back(C_RUN | C_ZLOOUT | C_GRA | C_RIN);
        end else if (op == 5'd15 || op == 5'd16) begin
            steps.push_back(C_RUN | C_GRA | C_ROUT | C_YIN);
            steps.push_back(C_RUN | C_GRB | C_ROUT | C_ZIN);
            steps.push_back(C_RUN | C_ZLOOUT | C_LOIN);
            steps.push_back(C_RUN | C_ZHIOUT | C_HIIN);
        end else if (op == 5'd0 || op == 5'd2) begin
            steps.push_back(C_RUN | C_GRB | C_BAOUT | C_ROUT | C_YIN);
            steps.push_back(C_RUN | C_COUT | C_ZIN);
            steps.push_back(C_RUN | C_ZLOOUT | C_MARIN);
            if (op == 5'd0) begin
                steps.push_back(C_RUN);
                steps.push_back(C_RUN | C_READ | C_MDRIN);
                steps.push_back(C_RUN | C_MDROUT | C_GRA | C_RIN);
            end else begin
                steps.push_back(C_RUN | C_GRA | C_ROUT | C_MDRIN);
                steps.push_back(C_RUN | C_WRITE);
            end
        end else if (op == 5'd19) begin
            steps.push_back(C_RUN | C_GRA | C_ROUT | C_CONIN);
            steps.push_back(C_RUN | C_PCOUT | C_YIN);
            steps.push_back(C_RUN | C_COUT | C_ZIN);
            steps.push_back(con ? (C_RUN | C_ZLOOUT | C_PCIN) : C_RUN);
        end else if (op == 5'd20) begin
            steps.push_back(C_RUN | C_GRA | C_ROUT | C_PCIN);
        end else if (op == 5'd21) begin
            steps.push_back(C_RUN | C_PCOUT | C_LINK);
            steps.push_back(C_RUN | C_GRA | C_ROUT | C_PCIN);
        end else if (op == 5'd22) begin
            steps.push_back(C_RUN | C_INOUT | C_GRA | C_RIN);
        end else if (op == 5'd23) begin
            steps.push_back(C_RUN | C_GRA | C_ROUT | C_OUTIN);
        end else if (op == 5'd24) begin
            steps.push_back(C_RUN | C_HIOUT | C_GRA | C_RIN);
        end else if (op == 5'd25) begin
            steps.push_back(C_RUN | C_LOOUT | C_GRA | C_RIN);
        end else begin
            steps.push_back(C_RUN);
            cur_halt = (op == 5'd27);
        end
    endfunction

    function automatic instr_t next_instr();
        instr_t      r;
        logic [31:0] w;
        logic [4:0]  op;
        if (prog.size() > 0) return prog.pop_front();
        w  = $urandom;
        op = 5'($urandom_range(0, 31));
        if (op == 5'd27 && $urandom_range(0, 3) != 0) op = 5'd26;
        w[31:27]   = op;
        r.ir       = w;
        r.con      = 1'($urandom_range(0, 1));
        r.stop_n   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
        r.clr_step = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 9)) : -1;
        return r;
    endfunction

    function automatic instr_t mk(input logic [31:0] ir, input bit con,
                                  input int stop_n, input int clr_step);
        instr_t r;
        r.ir = ir; r.con = con; r.stop_n = stop_n; r.clr_step = clr_step;
        return r;
    endfunction

    // Monitor: one control word is presented every cycle; compare mid-cycle.
    initial begin
        logic [43:0] got, e;
        forever begin
            @(negedge Clock);
            cyc++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = sample();
                n_chk++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL ctrl_word cycle %0d: got %011h expected %011h", cyc, got, e);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected end");
        $fatal(1, "watchdog");
    end

    initial begin
        mode_t       mode;
        instr_t      cur;
        bit          have_cur, clr_v, stop_v;
        int          idx, stop_left, halt_cnt, reset_left, n_instr;
        logic [43:0] exp_w;

        prog.push_back(mk(32'h18A00000, 1'b0, 0, -1));
        prog.push_back(mk(32'h00800065, 1'b0, 0, -1));
        prog.push_back(mk(32'h10800012, 1'b0, 0, 7));
        prog.push_back(mk(32'h99000005, 1'b0, 0, -1));
        prog.push_back(mk(32'h99000005, 1'b1, 0, -1));
        prog.push_back(mk(32'h99000005, 1'b1, 4, -1));
        prog.push_back(mk(32'h99000005, 1'b0, 4, -1));
        prog.push_back(mk(32'hA8800000, 1'b0, 0, -1));
        prog.push_back(mk(32'hD8000000, 1'b0, 0, -1));

        clr = 1'b1; cif.Stop = 1'b0; cif.IR = 32'h0; cif.CON = 1'b0;
        mode = M_RESET; have_cur = 1'b0; cur_halt = 1'b0;
        idx = 0; stop_left = 0; halt_cnt = 0; reset_left = 2; n_instr = 0;
        cur = mk(32'h0, 1'b0, 0, -1);
        @(posedge Clock);

        while (!(n_instr >= N_TOTAL && mode == M_RUN && !have_cur)) begin
            #1;
            clr_v = 1'b0; stop_v = 1'b0;
            if (mode == M_RESET) begin
                exp_w = 44'h0;
                if (reset_left > 0) begin clr_v = 1'b1; reset_left--; end
            end else if (mode == M_HALT) begin
                exp_w = 44'h0;
                halt_cnt++;
                if (halt_cnt >= 20) clr_v = 1'b1;
            end else if (steps.size() == 0) begin
                if (!have_cur) begin
                    cur = next_instr(); have_cur = 1'b1;
                    stop_left = cur.stop_n; idx = 0; n_instr++;
                end
                if (cur.clr_step == idx) clr_v = 1'b1;
                if (stop_left > 0) begin
                    stop_v = 1'b1; stop_left--; exp_w = C_RUN;
                end else begin
                    load_seq(cur.ir[31:27], cur.con);
                    cif.CON = cur.con;
                    exp_w = steps.pop_front(); idx++;
                end
            end else begin
                if (idx == 4) cif.IR = cur.ir;
                if (cur.clr_step == idx) clr_v = 1'b1;
                exp_w = steps.pop_front(); idx++;
            end

            clr = clr_v; cif.Stop = stop_v;
            exp_q.push_back(exp_w);

            if (clr_v) begin
                mode = M_RESET; steps.delete(); have_cur = 1'b0; cur_halt = 1'b0;
            end else if (mode == M_RESET) begin
                mode = M_RUN;
            end else if (mode == M_RUN && have_cur && steps.size() == 0 && !stop_v) begin
                if (cur_halt) begin mode = M_HALT; halt_cnt = 0; cur_halt = 1'b0; end
                have_cur = 1'b0;
            end
            @(posedge Clock);
        end

        @(negedge Clock); #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Microprogram-free, hardwired control sequencer for the mini-SRC CPU; drives every control input of `datapath` and consumes its `IRregister` and `CON` outputs. Runs a fixed fetch sequence and then an opcode-specific execute sequence, one control step per clock. Stops in a halt state on `halt`.

## Interface
Parameters: none. Opcode values and state encodings come from the shared package.

- `Clock`  in  1  sole clock; all state changes occur on its rising edge.
- `clr`  in  1  synchronous, active-high reset.
- `Stop`  in  1  when high in T0, hold in T0 with all controls 0 (pause).
- `IR`  in  32  from datapath `IRregister`; opcode is `IR[31:27]`.
- `CON`  in  1  branch condition from datapath CON flop.
- `Run`  out  1  high in every state except RESET and HALT.
- Register-enable outputs, each 1 bit: `HIin LOin PCin MDRin Zin Yin MARin IRin CONin OUTPORTin`.
- Bus-select outputs, each 1 bit: `HIout LOout ZHIout ZLOout PCout MDRout INPORTout Cout`.
- Register-file outputs, each 1 bit: `Gra Grb Grc Rin Rout BAout`.
- Memory and PC outputs, each 1 bit: `Read IncPC write`.
- `regIn`  out  16  direct GPR load enables. Only bit 15 is ever driven (jal link). All other bits are tied 0.

## Operation
- Opcodes, 5-bit: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011, addi 01100, andi 01101, ori 01110, mul 01111, div 10000, neg 10001, not 10010, br 10011, jr 10100, jal 10101, in 10110, out 10111, mfhi 11000, mflo 11001, nop 11010, halt 11011.
- Undefined opcodes execute as nop.
- States: RESET, T0–T9, HALT. Outputs are a Moore decode of the state and the registered `IR`. Any control not listed for a step is 0.
- Fetch sequence:
  - T0: PCout MARin IncPC Zin
  - T1: ZLOout PCin (memory-latency slot)
  - T2: Read MDRin
  - T3: MDRout IRin
- Execute sequences, starting at T4:
  - R-type ALU (add..rol): T4 Grb Rout Yin; T5 Grc Rout Zin; T6 ZLOout Gra Rin.
  - addi/andi/ori/ldi: T4 Grb Rout Yin, plus BAout for ldi only; T5 Cout Zin; T6 ZLOout Gra Rin.
  - neg/not: T4 Grb Rout Zin; T5 ZLOout Gra Rin.
  - mul/div: T4 Gra Rout Yin; T5 Grb Rout Zin; T6 ZLOout LOin; T7 ZHIout HIin.
  - ld: T4 Grb BAout Rout Yin; T5 Cout Zin; T6 ZLOout MARin; T7 idle; T8 Read MDRin; T9 MDRout Gra Rin.
  - st: T4 Grb BAout Rout Yin; T5 Cout Zin; T6 ZLOout MARin; T7 Gra Rout MDRin; T8 write.
  - br: T4 Gra Rout CONin; T5 PCout Yin; T6 Cout Zin; T7 ZLOout PCin only if CON=1, otherwise no controls.
  - jr: T4 Gra Rout PCin.
  - jal: T4 PCout regIn[15]; T5 Gra Rout PCin.
  - in: T4 INPORTout Gra Rin. out: T4 Gra Rout OUTPORTin.
  - mfhi: T4 HIout Gra Rin. mflo: T4 LOout Gra Rin.
  - nop: T4 with no controls.
- After the last step of a sequence, the next state is T0.
- halt: T4 goes to HALT. HALT holds, with all outputs 0, until `clr`.

## Timing
- `clr` sampled high → next state RESET. In RESET all outputs are 0, including `Run`.
- RESET → T0 on the first edge with `clr` low.
- `clr` mid-instruction abandons the instruction. The cycle after the `clr` edge has all outputs 0, so no `write`, `Rin` or `PCin` leaks.
- `clr` has priority over `Stop` and over HALT.
- `Stop` is sampled only in T0. While high, the state stays T0 and T0 controls are suppressed; PC does not advance.
- Each step lasts exactly 1 clock. Instruction lengths in cycles, fetch included:
  - jr, in, out, mfhi, mflo, nop: 5
  - neg, not: 6
  - ALU, immediate, ldi, jal: 7 (jal is 6)
  - mul, div, br, st: 8 (st is 9)
  - ld: 10
- CON is latched at the end of br T4 and sampled at T7.
- `IR` changes only at the T3 edge, so decode is stable from T4 through the end of the instruction.

## Structure
- Package `cpu_pkg`:
  - 5-bit opcode localparams
  - state enum (RESET, T0–T9, HALT)
  - instruction-class grouping function: ALU, IMM, UNARY, MULDIV, LOAD, STORE, BRANCH, JUMP, IO, MOVE, NOP, HALT
- Single module: state register plus combinational output decode. No sub-module.

## Test plan
- Reset sequence: hold `clr` 3 cycles → `Run`=0 and all outputs 0 during reset. First cycle after release is RESET; next cycle is T0 with PCout=MARin=IncPC=Zin=1.
- `IR`=0x18A00000 (add R1,R2,R4): T4 Grb/Rout/Yin, T5 Grc/Rout/Zin, T6 ZLOout/Gra/Rin, then T0 again. 7 cycles total.
- ld (IR=0x00800065): check `Read`/`MDRin` at T8 only and `MDRout`/`Gra`/`Rin` at T9. `write` stays 0 throughout.
- br with CON=0 vs CON=1: PCin asserted at T7 only when CON=1, both sequences 8 cycles. Repeat with `Stop`=1 in T0 for 4 cycles → state held, PCin never asserted.
- Mid-instruction reset: `clr` pulsed at st T7 → `write` never asserted, then normal fetch resumes.
- halt (IR=0xD8000000): HALT reached after T4, `Run`=0, outputs stay 0 for 20 cycles until `clr`.
